// File: rtl/starter_pkg.sv
// Shared types and constants for the starter-selection screen.
// The state encoding is also consumed by the screen renderer.
package starter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BROWSE  = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    // Species IDs of the default starter line-up (BASE_ID = 3).
    localparam logic [4:0] ID_STARTER0 = 5'd3;
    localparam logic [4:0] ID_STARTER1 = 5'd4;
    localparam logic [4:0] ID_STARTER2 = 5'd5;

    // Cursor width; a single-option screen still needs a 1-bit bus.
    function automatic int cur_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/starter_select_fsm_edge_detect.sv
// Rising-edge press detector for one already-synchronised button level.
module edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic level_i,
    output logic press_o
);

    logic level_q;

    // NOTE: history resets to 1 so a button held through reset is not a press.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_i;
        end
    end

    assign press_o = level_i & ~level_q;

endmodule

// File: rtl/starter_select_fsm.sv
// Starter-selection screen: cursor browsing, two-step confirm, and a
// species ID that stays locked until reset once the choice is confirmed.
module starter_select_fsm
    import starter_pkg::*;
#(
    parameter  int NUM_STARTERS = 3,
    parameter  int ID_WIDTH     = 5,
    parameter  int BASE_ID      = 3,
    parameter  int WRAP         = 1,
    localparam int CUR_W        = cur_width(NUM_STARTERS)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                enable,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_a,
    input  logic                btn_b,
    input  logic [ID_WIDTH-1:0] prev_ID,
    output logic [CUR_W-1:0]    cursor,
    output logic [1:0]          state,
    output logic [ID_WIDTH-1:0] new_ID,
    output logic                done
);

    localparam logic [CUR_W-1:0] LAST = CUR_W'(NUM_STARTERS - 1);

    generate
        if (NUM_STARTERS < 1) begin : g_bad_count
            $error("starter_select_fsm: NUM_STARTERS must be at least 1");
        end
        if (BASE_ID + NUM_STARTERS - 1 >= (1 << ID_WIDTH)) begin : g_bad_range
            $error("starter_select_fsm: highest starter ID does not fit in ID_WIDTH");
        end
    endgenerate

    logic press_left, press_right, press_a, press_b;

    edge_detect u_edge_left  (.Clk(Clk), .Reset(Reset), .level_i(btn_left),  .press_o(press_left));
    edge_detect u_edge_right (.Clk(Clk), .Reset(Reset), .level_i(btn_right), .press_o(press_right));
    edge_detect u_edge_a     (.Clk(Clk), .Reset(Reset), .level_i(btn_a),     .press_o(press_a));
    edge_detect u_edge_b     (.Clk(Clk), .Reset(Reset), .level_i(btn_b),     .press_o(press_b));

    state_e                state_q, state_d;
    logic [CUR_W-1:0]      cursor_q, cursor_d;
    logic [ID_WIDTH-1:0]   locked_id_q, locked_id_d;
    logic                  done_q, done_d;

    // Cursor targets for a single-direction press, honouring WRAP.
    logic [CUR_W-1:0] cursor_dec, cursor_inc;

    always_comb begin
        if (cursor_q == '0) begin
            cursor_dec = (WRAP != 0) ? LAST : '0;
        end else begin
            cursor_dec = cursor_q - CUR_W'(1);
        end
        if (cursor_q >= LAST) begin
            cursor_inc = (WRAP != 0) ? '0 : LAST;
        end else begin
            cursor_inc = cursor_q + CUR_W'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        locked_id_d = locked_id_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = BROWSE;
                    cursor_d = '0;
                end
            end
            BROWSE: begin
                if (!enable) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end else if (press_a) begin
                    state_d = CONFIRM;
                end else if (press_left && !press_right) begin
                    cursor_d = cursor_dec;
                end else if (press_right && !press_left) begin
                    cursor_d = cursor_inc;
                end
            end
            CONFIRM: begin
                if (!enable) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end else if (press_b) begin
                    state_d = BROWSE;
                end else if (press_a) begin
                    state_d     = LOCKED;
                    locked_id_d = ID_WIDTH'(BASE_ID) + ID_WIDTH'(cursor_q);
                    done_d      = 1'b1;
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d  = IDLE;
                cursor_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cursor_q    <= '0;
            locked_id_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            locked_id_q <= locked_id_d;
            done_q      <= done_d;
        end
    end

    assign cursor = cursor_q;
    assign state  = state_q;
    assign done   = done_q;
    assign new_ID = (state_q == LOCKED) ? locked_id_q : prev_ID;

endmodule

// File: tb/tb_starter_select_fsm.sv
// Self-checking bench: WRAP=1 and WRAP=0 instances driven in parallel and
// compared every cycle against a behavioural screen model.
module tb_starter_select_fsm;
    import starter_pkg::*;

    localparam int N    = 3;
    localparam int BASE = 3;

    logic       Clk;
    logic       Reset;
    logic       enable;
    logic       btn_left, btn_right, btn_a, btn_b;
    logic [4:0] prev_ID;

    logic [1:0] cursor_w1, cursor_w0;
    logic [1:0] state_w1, state_w0;
    logic [4:0] new_id_w1, new_id_w0;
    logic       done_w1, done_w0;

    int checks = 0;
    int errors = 0;

    starter_select_fsm #(.NUM_STARTERS(N), .ID_WIDTH(5), .BASE_ID(BASE), .WRAP(1)) u_w1 (
        .Clk(Clk), .Reset(Reset), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_a(btn_a), .btn_b(btn_b),
        .prev_ID(prev_ID), .cursor(cursor_w1), .state(state_w1),
        .new_ID(new_id_w1), .done(done_w1)
    );

    starter_select_fsm #(.NUM_STARTERS(N), .ID_WIDTH(5), .BASE_ID(BASE), .WRAP(0)) u_w0 (
        .Clk(Clk), .Reset(Reset), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_a(btn_a), .btn_b(btn_b),
        .prev_ID(prev_ID), .cursor(cursor_w0), .state(state_w0),
        .new_ID(new_id_w0), .done(done_w0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = WRAP=1 screen, index 1 = WRAP=0 screen.
    // Phase numbers are the screen phases 0 idle, 1 browse, 2 confirm, 3 locked.
    int m_phase[2];
    int m_cur[2];
    int m_lock[2];
    int m_done[2];
    bit m_last[4];  // last sampled level of left, right, a, b

    task automatic model_step();
        bit lv[4];
        bit pr[4];
        lv = '{btn_left, btn_right, btn_a, btn_b};
        if (Reset) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] = 0; m_cur[k] = 0; m_lock[k] = 0; m_done[k] = 0;
            end
            m_last = '{1, 1, 1, 1};
            return;
        end
        for (int i = 0; i < 4; i++) begin
            pr[i] = lv[i] && !m_last[i];
            m_last[i] = lv[i];
        end
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            if (m_phase[k] == 3) continue;
            if (m_phase[k] == 0) begin
                if (enable) begin m_phase[k] = 1; m_cur[k] = 0; end
            end else if (!enable) begin
                m_phase[k] = 0; m_cur[k] = 0;
            end else if (m_phase[k] == 1) begin
                if (pr[2]) m_phase[k] = 2;
                else if (pr[0] && !pr[1])
                    m_cur[k] = (k == 0) ? (m_cur[k] + N - 1) % N
                                        : ((m_cur[k] > 0) ? m_cur[k] - 1 : 0);
                else if (pr[1] && !pr[0])
                    m_cur[k] = (k == 0) ? (m_cur[k] + 1) % N
                                        : ((m_cur[k] < N - 1) ? m_cur[k] + 1 : N - 1);
            end else begin
                if (pr[3]) m_phase[k] = 1;
                else if (pr[2]) begin
                    m_phase[k] = 3; m_lock[k] = BASE + m_cur[k]; m_done[k] = 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        int exp_id;
        for (int k = 0; k < 2; k++) begin
            exp_id = (m_phase[k] == 3) ? m_lock[k] : int'(prev_ID);
            if (k == 0) begin
                check("w1.state",  state_w1,  m_phase[k]);
                check("w1.cursor", cursor_w1, m_cur[k]);
                check("w1.new_ID", new_id_w1, exp_id);
                check("w1.done",   done_w1,   m_done[k]);
            end else begin
                check("w0.state",  state_w0,  m_phase[k]);
                check("w0.cursor", cursor_w0, m_cur[k]);
                check("w0.new_ID", new_id_w0, exp_id);
                check("w0.done",   done_w0,   m_done[k]);
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare on the falling edge.
    task automatic apply(input bit rst, input bit en, input bit l, input bit r,
                         input bit a, input bit b, input logic [4:0] prev);
        Reset = rst; enable = en;
        btn_left = l; btn_right = r; btn_a = a; btn_b = b;
        prev_ID = prev;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        compare_model();
    endtask

    typedef struct {
        bit rst, en, l, r, a, b;
        logic [4:0] prev;
        int st, cur, nid, dn;
    } vec_t;

    function automatic vec_t v(input bit rst, input bit en, input bit l, input bit r,
                               input bit a, input bit b, input logic [4:0] prev,
                               input int st, input int cur, input int nid, input int dn);
        vec_t x;
        x.rst = rst; x.en = en; x.l = l; x.r = r; x.a = a; x.b = b; x.prev = prev;
        x.st = st; x.cur = cur; x.nid = nid; x.dn = dn;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        // Expected values below are for the WRAP=1 instance after each edge.
        tbl.push_back(v(1,0,0,0,0,0, 5'd9,  0,0, 9,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd9,  1,0, 9,0));
        tbl.push_back(v(0,1,0,1,0,0, 5'd9,  1,1, 9,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd9,  1,1, 9,0));
        tbl.push_back(v(0,1,0,1,0,0, 5'd9,  1,2, 9,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd9,  1,2, 9,0));
        tbl.push_back(v(0,1,0,0,1,0, 5'd9,  2,2, 9,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd9,  2,2, 9,0));
        tbl.push_back(v(0,1,0,0,1,0, 5'd9,  3,2, int'(ID_STARTER2),1));
        tbl.push_back(v(0,1,0,0,0,0, 5'd9,  3,2, 5,0));
        tbl.push_back(v(0,0,1,1,1,1, 5'd12, 3,2, 5,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd12, 3,2, 5,0));
        tbl.push_back(v(1,1,0,0,0,0, 5'd7,  0,0, 7,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd7,  1,0, 7,0));
        tbl.push_back(v(0,1,1,0,0,0, 5'd7,  1,2, 7,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd7,  1,2, 7,0));
        tbl.push_back(v(0,1,1,1,0,0, 5'd7,  1,2, 7,0));
        tbl.push_back(v(0,1,0,0,0,0, 5'd7,  1,2, 7,0));

        Reset = 1'b1; enable = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        prev_ID = 5'd9;

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].prev);
            check($sformatf("vec%0d.state", i),  state_w1,  tbl[i].st);
            check($sformatf("vec%0d.cursor", i), cursor_w1, tbl[i].cur);
            check($sformatf("vec%0d.new_ID", i), new_id_w1, tbl[i].nid);
            check($sformatf("vec%0d.done", i),   done_w1,   tbl[i].dn);
        end

        // Left at cursor 0: wraps on WRAP=1, saturates on WRAP=0.
        apply(1,0,0,0,0,0, 5'd9);
        apply(0,1,0,0,0,0, 5'd9);
        apply(0,1,1,0,0,0, 5'd9);
        check("wrap_left.w1", cursor_w1, 2);
        check("sat_left.w0",  cursor_w0, 0);
        apply(0,1,0,0,0,0, 5'd9);

        // Held right moves exactly once; release then press moves again.
        for (int i = 0; i < 10; i++) apply(0,1,0,1,0,0, 5'd9);
        check("hold_right.w1", cursor_w1, 0);
        check("hold_right.w0", cursor_w0, 1);
        apply(0,1,0,0,0,0, 5'd9);
        apply(0,1,0,1,0,0, 5'd9);
        check("repress.w0", cursor_w0, 2);
        apply(0,1,0,0,0,0, 5'd9);
        apply(0,1,0,1,0,0, 5'd9);
        check("sat_right.w0", cursor_w0, 2);
        apply(0,1,0,0,0,0, 5'd9);

        // A and B together in CONFIRM: B wins, back to BROWSE, no done.
        apply(0,1,0,0,1,0, 5'd9);
        check("to_confirm", state_w0, 2);
        apply(0,1,0,0,0,0, 5'd9);
        apply(0,1,0,0,1,1, 5'd9);
        check("ab_back.state", state_w0, 1);
        check("ab_back.done",  done_w0,  0);
        apply(0,1,0,0,0,0, 5'd9);

        // Enable drop in CONFIRM beats a simultaneous A press.
        apply(0,1,0,0,1,0, 5'd9);
        apply(0,1,0,0,0,0, 5'd9);
        apply(0,0,0,0,1,0, 5'd17);
        check("en_drop.state",  state_w0,  0);
        check("en_drop.cursor", cursor_w0, 0);
        check("en_drop.new_ID", new_id_w0, 17);

        // A held through reset and for 3 cycles after is not a press.
        apply(1,1,0,0,1,0, 5'd9);
        for (int i = 0; i < 3; i++) apply(0,1,0,0,1,0, 5'd9);
        apply(0,1,0,0,0,0, 5'd9);
        check("held_a.state", state_w1, 1);
        apply(0,1,0,0,1,0, 5'd9);
        apply(0,1,0,0,0,0, 5'd9);
        apply(0,1,0,0,1,0, 5'd9);
        check("lock0.new_ID", new_id_w1, int'(ID_STARTER0));
        check("lock0.done",   done_w1,   1);

        // Reset while LOCKED returns to IDLE and restores passthrough.
        apply(1,1,0,0,0,0, 5'd21);
        check("rst_locked.state",  state_w1,  0);
        check("rst_locked.new_ID", new_id_w1, 21);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(63) == 0),
                  ($urandom_range(7) != 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(4) == 0),
                  5'($urandom_range(31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/starter_select_fsm.md
Name: starter_select_fsm

Overview:
- Sequential successor to the combinational starter-ID mapper.
- Runs the starter-selection screen: the player moves a cursor over NUM_STARTERS options with left/right, presses A once to highlight and again to confirm, and B backs out.
- When confirmed, the chosen species ID is locked until reset and drives the party/battle logic. Until then the incoming prev_ID passes through unchanged.

Parameters:
- NUM_STARTERS, 3, number of selectable starters (>=1).
- ID_WIDTH, 5, width of the species ID bus.
- BASE_ID, 3, species ID of cursor position 0; position k maps to BASE_ID+k.
- WRAP, 1, 1 = cursor wraps at both ends; 0 = cursor saturates at the ends.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- enable  in  1  starter screen active (level).
- btn_left  in  1  left key, level, already synchronised.
- btn_right  in  1  right key, level.
- btn_a  in  1  confirm key, level.
- btn_b  in  1  cancel key, level.
- prev_ID  in  ID_WIDTH  current party-lead ID.
- cursor  out  CUR_W  highlighted option; CUR_W = max(1, $clog2(NUM_STARTERS)).
- state  out  2  current FSM state, for the screen renderer.
- new_ID  out  ID_WIDTH  selected ID.
- done  out  1  one-cycle pulse when the selection locks.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high; every flop is cleared only on a Clk edge with Reset=1.
- Reset values:
  - state=IDLE, cursor=0, locked_id=0, done=0.
  - All button history flops are set to 1, so a button held through reset does not register as a press.
- Press detection: press_x = btn_x & ~btn_q_x, where btn_q_x is btn_x registered every cycle.
  - A held button produces exactly one press.
  - A button must be seen low for one sampled cycle before it can press again.
- Latency: a press sampled at edge k takes effect on state/cursor after edge k. Outputs are registered, so there is one cycle from press to output.
- States and transitions:
  - IDLE: enable=1 -> BROWSE, cursor=0. Presses are ignored while in IDLE.
  - BROWSE:
    - left moves cursor -1; right moves +1.
    - left and right in the same cycle: no move.
    - At cursor 0 with left: WRAP=1 -> NUM_STARTERS-1; WRAP=0 -> stays 0.
    - At NUM_STARTERS-1 with right: WRAP=1 -> 0; WRAP=0 -> stays.
    - NUM_STARTERS=1: cursor is always 0.
    - A -> CONFIRM, cursor unchanged. A together with a direction in the same cycle: A wins, no move.
    - B is ignored.
  - CONFIRM:
    - A -> LOCKED; locked_id <= BASE_ID + cursor; done=1 for the entry cycle only.
    - B -> BROWSE.
    - A and B in the same cycle: B wins.
    - Directions are ignored.
  - LOCKED:
    - Terminal state; only Reset leaves it.
    - Ignores all buttons and ignores enable.
- enable dropping in BROWSE or CONFIRM -> IDLE, cursor=0, no lock. enable has priority over any press in that cycle.
- new_ID:
  - In LOCKED: locked_id.
  - In every other state: prev_ID (combinational passthrough).
- Arithmetic:
  - BASE_ID + cursor is computed at ID_WIDTH width, with cursor zero-extended.
  - Elaboration assertion: BASE_ID + NUM_STARTERS - 1 < 2**ID_WIDTH.
- Reset mid-operation, including while LOCKED: returns to IDLE on that edge and new_ID reverts to prev_ID.

Decomposition:
- starter_pkg holds:
  - the state enum (IDLE=0, BROWSE=1, CONFIRM=2, LOCKED=3), also used by the renderer;
  - species ID constants for the starters (for example ID_STARTER0=5'd3, 5'd4, 5'd5).
- Sub-module edge_detect:
  - one per button;
  - Clk, Reset, level in, press out;
  - its history flop resets to 1.
- The FSM, cursor arithmetic and output mux live in the top module.

Test Plan:
- Reset, then enable=1; press right twice, then A, then A -> cursor 0->1->2; state BROWSE->CONFIRM->LOCKED; new_ID=5'd5; done high for exactly 1 cycle; prev_ID=5'd9 passes through before lock.
- WRAP=1: from cursor 0, press left -> cursor=2. WRAP=0: from cursor 0, press left -> cursor stays 0. WRAP=0: from cursor 2, press right -> cursor stays 2.
- Hold right for 10 cycles -> cursor advances by exactly 1. Release for 1 cycle, then press again -> advances again.
- In CONFIRM, assert A and B on the same cycle -> state BROWSE, no done. Left+right on the same cycle in BROWSE -> cursor unchanged.
- Drop enable during CONFIRM while pressing A -> state IDLE, cursor 0, new_ID=prev_ID. After LOCKED, toggle enable and all buttons -> new_ID stays the locked value.
- Hold btn_a through Reset; release 3 cycles after reset -> no press is registered. Assert Reset while LOCKED -> next cycle state=IDLE, new_ID=prev_ID.
